// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache controller between the fetch and data ports.
// Holds the grant for the whole access and aborts stuck accesses through a watchdog.
module cache_req_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    output logic [15:0] i_data_out,
    output logic        i_done,
    output logic        i_stall,
    output logic        i_cachehit,
    output logic        i_err,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    input  logic        d_rd,
    input  logic        d_wr,
    output logic [15:0] d_data_out,
    output logic        d_done,
    output logic        d_stall,
    output logic        d_cachehit,
    output logic        d_err,
    output logic [15:0] c_addr,
    output logic [15:0] c_data_in,
    output logic        c_rd,
    output logic        c_wr,
    input  logic [15:0] c_data_out,
    input  logic        c_done,
    input  logic        c_cachehit,
    input  logic        c_err,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    logic             r_last_d;
    logic [CNT_W-1:0] r_wdog;
    logic [15:0]      r_addr;
    logic [15:0]      r_data;
    logic             r_op_rd;
    logic             r_op_wr;
    logic             r_timeout;

    logic w_req_i, w_req_d, w_illegal, w_idle, w_busy;
    logic w_gnt_i, w_gnt_d, w_expire, w_finish;

    assign w_req_i   = i_rd;
    assign w_req_d   = d_rd ^ d_wr;
    assign w_illegal = d_rd & d_wr;
    assign w_idle    = (r_state == IDLE);
    assign w_busy    = ~w_idle;

    // On a tie the port that did not win last time gets the grant.
    assign w_gnt_i  = w_idle & w_req_i & (~w_req_d | r_last_d);
    assign w_gnt_d  = w_idle & w_req_d & ~w_gnt_i;
    assign w_expire = w_busy & ~c_done & (r_wdog == TO_LAST);
    assign w_finish = w_busy & (c_done | w_expire);

    assign c_rd         = w_busy & r_op_rd;
    assign c_wr         = w_busy & r_op_wr;
    assign c_addr       = r_addr;
    assign c_data_in    = r_data;
    assign timeout_flag = r_timeout;

    always_comb begin
        i_done     = 1'b0;
        i_data_out = 16'h0000;
        i_cachehit = 1'b0;
        i_err      = 1'b0;
        d_done     = 1'b0;
        d_data_out = 16'h0000;
        d_cachehit = 1'b0;
        d_err      = 1'b0;
        if (r_state == GNT_I) begin
            i_done     = w_finish;
            i_data_out = c_done ? c_data_out : 16'h0000;
            i_cachehit = c_done & c_cachehit;
            i_err      = c_done ? c_err : w_expire;
        end
        if (r_state == GNT_D) begin
            d_done     = w_finish;
            d_data_out = c_done ? c_data_out : 16'h0000;
            d_cachehit = c_done & c_cachehit;
            d_err      = c_done ? c_err : w_expire;
        end
        // A load+store request is rejected on the spot without touching the controller.
        if (w_idle & w_illegal & rst_n) begin
            d_done = 1'b1;
            d_err  = 1'b1;
        end
        i_stall = rst_n & w_req_i & ~i_done;
        d_stall = rst_n & w_req_d & ~d_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b1;
            r_wdog    <= '0;
            r_addr    <= 16'h0000;
            r_data    <= 16'h0000;
            r_op_rd   <= 1'b0;
            r_op_wr   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_i) begin
                        r_state  <= GNT_I;
                        r_last_d <= 1'b0;
                        r_wdog   <= '0;
                        r_addr   <= i_addr;
                        r_data   <= 16'h0000;
                        r_op_rd  <= 1'b1;
                        r_op_wr  <= 1'b0;
                    end else if (w_gnt_d) begin
                        r_state  <= GNT_D;
                        r_last_d <= 1'b1;
                        r_wdog   <= '0;
                        r_addr   <= d_addr;
                        r_data   <= d_data_in;
                        r_op_rd  <= d_rd;
                        r_op_wr  <= d_wr;
                    end
                end
                GNT_I, GNT_D: begin
                    if (w_finish) begin
                        r_state <= IDLE;
                        if (w_expire) r_timeout <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Randomized bench for cache_req_arbiter checked every cycle against a port-level
// model of ownership, round-robin fairness and watchdog expiry.
module tb_cache_req_arbiter;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_rd = 1'b0;
    logic [15:0] i_data_out;
    logic        i_done, i_stall, i_cachehit, i_err;
    logic [15:0] d_addr = '0;
    logic [15:0] d_data_in = '0;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_data_out;
    logic        d_done, d_stall, d_cachehit, d_err;
    logic [15:0] c_addr, c_data_in;
    logic        c_rd, c_wr;
    logic [15:0] c_data_out = '0;
    logic        c_done = 1'b0;
    logic        c_cachehit = 1'b0;
    logic        c_err = 1'b0;
    logic        timeout_flag;

    always #5 clk = ~clk;

    cache_req_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_rd(i_rd), .i_data_out(i_data_out), .i_done(i_done),
        .i_stall(i_stall), .i_cachehit(i_cachehit), .i_err(i_err),
        .d_addr(d_addr), .d_data_in(d_data_in), .d_rd(d_rd), .d_wr(d_wr),
        .d_data_out(d_data_out), .d_done(d_done), .d_stall(d_stall),
        .d_cachehit(d_cachehit), .d_err(d_err),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_rd(c_rd), .c_wr(c_wr),
        .c_data_out(c_data_out), .c_done(c_done), .c_cachehit(c_cachehit),
        .c_err(c_err), .timeout_flag(timeout_flag)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who owns the controller (0 none, 1 fetch, 2 data) and what it latched.
    int          m_owner;
    int          m_waited;
    bit          m_last_d;
    logic [15:0] m_addr, m_data;
    bit          m_rd, m_wr, m_flag;

    // Controller responder: answers r_lat cycles into the grant (1000 = never).
    int          r_lat = 0;
    logic [15:0] r_data = '0;
    bit          r_hit = 0, r_err = 0;
    bit          rand_resp = 0;

    bit e_i_done, e_d_done;
    bit i_want, d_want;

    task automatic model_reset();
        m_owner = 0; m_waited = 0; m_last_d = 1;
        m_addr = '0; m_data = '0; m_rd = 0; m_wr = 0; m_flag = 0;
    endtask

    // Called 1 time unit after a rising edge with inputs already driven.
    task automatic cycle();
        logic [15:0] ei_data = '0, ed_data = '0;
        bit ei_done = 0, ei_hit = 0, ei_err = 0, ed_done = 0, ed_hit = 0, ed_err = 0;
        bit e_crd = 0, e_cwr = 0, timeout_now = 0, vi, vd;
        int nxt = m_owner;
        if (m_owner != 0 && m_waited >= r_lat) begin
            c_done = 1; c_data_out = r_data; c_cachehit = r_hit; c_err = r_err;
        end else begin
            c_done = 0; c_data_out = 16'($urandom); c_cachehit = 1'($urandom); c_err = 1'($urandom);
        end
        #2;
        vi = i_rd;
        vd = d_rd ^ d_wr;
        if (m_owner == 0) begin
            if (d_rd && d_wr) begin ed_done = 1; ed_err = 1; end
            if (vi && vd) nxt = m_last_d ? 1 : 2;
            else if (vi) nxt = 1;
            else if (vd) nxt = 2;
        end else begin
            e_crd = m_rd;
            e_cwr = m_wr;
            timeout_now = !c_done && (m_waited == TIMEOUT - 1);
            if (c_done || timeout_now) begin
                nxt = 0;
                if (m_owner == 1) begin
                    ei_done = 1; ei_data = c_done ? r_data : 16'h0;
                    ei_hit = c_done & r_hit; ei_err = c_done ? r_err : 1'b1;
                end else begin
                    ed_done = 1; ed_data = c_done ? r_data : 16'h0;
                    ed_hit = c_done & r_hit; ed_err = c_done ? r_err : 1'b1;
                end
            end
        end
        check_val("i_data_out", i_data_out, ei_data);
        check_val("i_done", 16'(i_done), 16'(ei_done));
        check_val("i_stall", 16'(i_stall), 16'(vi & !ei_done));
        check_val("i_cachehit", 16'(i_cachehit), 16'(ei_hit));
        check_val("i_err", 16'(i_err), 16'(ei_err));
        check_val("d_data_out", d_data_out, ed_data);
        check_val("d_done", 16'(d_done), 16'(ed_done));
        check_val("d_stall", 16'(d_stall), 16'(vd & !ed_done));
        check_val("d_cachehit", 16'(d_cachehit), 16'(ed_hit));
        check_val("d_err", 16'(d_err), 16'(ed_err));
        check_val("c_rd", 16'(c_rd), 16'(e_crd));
        check_val("c_wr", 16'(c_wr), 16'(e_cwr));
        check_val("c_addr", c_addr, m_addr);
        check_val("c_data_in", c_data_in, m_data);
        check_val("timeout_flag", 16'(timeout_flag), 16'(m_flag));
        e_i_done = ei_done;
        e_d_done = ed_done;
        @(posedge clk);
        #1;
        if (m_owner == 0 && nxt != 0) begin
            m_waited = 0;
            m_last_d = (nxt == 2);
            if (nxt == 1) begin
                m_addr = i_addr; m_data = '0; m_rd = 1; m_wr = 0;
            end else begin
                m_addr = d_addr; m_data = d_data_in; m_rd = d_rd; m_wr = d_wr;
            end
            if (rand_resp) begin
                case ($urandom % 20)
                    0: r_lat = 1000;
                    1: r_lat = TIMEOUT - 1;
                    default: r_lat = int'($urandom_range(0, 6));
                endcase
                r_data = 16'($urandom); r_hit = 1'($urandom); r_err = ($urandom % 5) == 0;
            end
        end else if (m_owner != 0) begin
            if (nxt == 0) begin
                if (timeout_now) m_flag = 1;
            end else begin
                m_waited++;
            end
        end
        m_owner = nxt;
    endtask

    task automatic check_all_zero();
        check_val("rst i_data_out", i_data_out, 16'h0);
        check_val("rst d_data_out", d_data_out, 16'h0);
        check_val("rst c_addr", c_addr, 16'h0);
        check_val("rst c_data_in", c_data_in, 16'h0);
        check_val("rst flags", {4'h0, i_done, i_stall, i_cachehit, i_err, d_done, d_stall,
                                d_cachehit, d_err, c_rd, c_wr, timeout_flag, 1'b0}, 16'h0);
    endtask

    // Runs until both ports are quiet; requests drop on their done pulse.
    task automatic run_directed(input int max_cycles, input bit addr_noise);
        for (int k = 0; k < max_cycles; k++) begin
            if (!i_rd && !d_rd && !d_wr && m_owner == 0) break;
            cycle();
            if (e_i_done) i_rd = 0;
            if (e_d_done) begin d_rd = 0; d_wr = 0; end
            if (addr_noise && m_owner != 0) begin
                d_addr = 16'($urandom); d_data_in = 16'($urandom); i_addr = 16'($urandom);
            end
        end
        check_val("drain", {13'h0, i_rd, d_rd, d_wr}, 16'h0);
    endtask

    task automatic drive_random();
        if (e_i_done) begin
            i_want = 0; i_rd = 0;
        end else if (i_want && m_owner == 1 && ($urandom % 8) == 0) begin
            i_rd = 0;
        end else if (!i_want && ($urandom % 3) == 0) begin
            i_want = 1; i_rd = 1; i_addr = 16'($urandom);
        end
        if (m_owner == 1) i_addr = 16'($urandom);
        if (e_d_done) begin
            d_want = 0; d_rd = 0; d_wr = 0;
        end else if (d_want && m_owner == 2 && ($urandom % 8) == 0) begin
            d_rd = 0; d_wr = 0;
        end else if (!d_want && ($urandom % 3) == 0) begin
            d_want = 1;
            d_addr = 16'($urandom); d_data_in = 16'($urandom);
            if (($urandom % 6) == 0) begin d_rd = 1; d_wr = 1; end
            else if (($urandom % 2) == 0) begin d_rd = 1; d_wr = 0; end
            else begin d_rd = 0; d_wr = 1; end
        end
        if (m_owner == 2) begin d_addr = 16'($urandom); d_data_in = 16'($urandom); end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero();
        rst_n = 1;

        // Single fetch hit.
        r_lat = 0; r_data = 16'hBEEF; r_hit = 1; r_err = 0;
        i_addr = 16'h0040; i_rd = 1;
        run_directed(10, 0);
        cycle();

        // Fetch and store tie, twice in a row.
        for (int n = 0; n < 2; n++) begin
            r_lat = 1; r_data = 16'h1111; r_hit = 0;
            i_addr = 16'h0100; i_rd = 1;
            d_addr = 16'h1234; d_data_in = 16'h5A5A; d_wr = 1;
            run_directed(30, 0);
        end

        // Long miss with address noise during the grant.
        r_lat = 20; r_data = 16'hC0DE; r_hit = 0;
        d_addr = 16'h2000; d_rd = 1;
        run_directed(40, 1);

        // Illegal load+store.
        d_rd = 1; d_wr = 1;
        cycle();
        d_rd = 0; d_wr = 0;
        cycle();

        // Watchdog expiry, recovery, then c_done landing on the last allowed cycle.
        r_lat = 1000; i_addr = 16'h0300; i_rd = 1;
        run_directed(80, 0);
        r_lat = 2; r_data = 16'h7777; r_hit = 1; d_addr = 16'h0400; d_rd = 1;
        run_directed(20, 0);
        r_lat = TIMEOUT - 1; r_data = 16'h4242; i_rd = 1;
        run_directed(80, 0);

        // Reset in the middle of a data access.
        r_lat = 1000; d_addr = 16'h0500; d_rd = 1;
        cycle(); cycle(); cycle();
        #2 rst_n = 0;
        #1 check_all_zero();
        @(posedge clk);
        #1;
        model_reset();
        d_rd = 0;
        rst_n = 1;
        r_lat = 0; r_data = 16'hAAAA; r_hit = 1;
        i_addr = 16'h0600; i_rd = 1; d_addr = 16'h0700; d_rd = 1;
        cycle();
        check_val("tie after reset", 16'(m_owner), 16'd1);
        run_directed(20, 0);

        // Randomized traffic.
        rand_resp = 1; i_want = 0; d_want = 0;
        for (int n = 0; n < 4000; n++) begin
            cycle();
            drive_random();
        end
        rand_resp = 0; r_lat = 0;
        i_rd = 0; d_rd = 0; d_wr = 0;
        run_directed(200, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
